// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the execute bundle, aligns/extends SRAM load data,
// builds per-byte write strobes for LWL/LWR merging, and holds the read word across stalls.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [95:0] es_to_ms_bus,
    input  logic [31:0] data_sram_rdata,
    input  logic        flush,
    output logic        ms_to_ws_valid,
    output logic [90:0] ms_to_ws_bus,
    output logic [42:0] ms_fwd_bus
);

    logic        ms_valid_q, ms_valid_d;
    logic [95:0] ms_bus_q, ms_bus_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic        rbuf_v_q, rbuf_v_d;

    logic [10:0] ms_root;
    logic        ms_bd, ms_ex, ms_mfc0;
    logic [4:0]  ms_excode, ms_dest;
    logic        ld_lw, ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lwl, ld_lwr;
    logic        ms_res_from_mem, ms_gr_we;
    logic [31:0] ms_res, ms_pc;
    logic [1:0]  p;

    logic [31:0] rd;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [3:0]  rf_wen;
    logic [31:0] final_result;

    assign ms_root         = ms_bus_q[95:85];
    assign ms_mfc0         = ms_bus_q[93];
    assign ms_bd           = ms_bus_q[84];
    assign ms_ex           = ms_bus_q[83];
    assign ms_excode       = ms_bus_q[82:78];
    assign {ld_lw, ld_lb, ld_lbu, ld_lh, ld_lhu, ld_lwl, ld_lwr} = ms_bus_q[77:71];
    assign ms_res_from_mem = ms_bus_q[70];
    assign ms_gr_we        = ms_bus_q[69];
    assign ms_dest         = ms_bus_q[68:64];
    assign ms_res          = ms_bus_q[63:32];
    assign ms_pc           = ms_bus_q[31:0];
    assign p               = ms_res[1:0];

    // MEM never stalls on its own, so ready_go is folded in as 1
    assign ms_allowin     = !ms_valid_q || ws_allowin;
    assign ms_to_ws_valid = ms_valid_q && !flush;

    always_comb begin
        ms_valid_d = ms_valid_q;
        ms_bus_d   = ms_bus_q;
        rbuf_d     = rbuf_q;
        rbuf_v_d   = rbuf_v_q;
        if (flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
            if (es_to_ms_valid) begin
                ms_bus_d = es_to_ms_bus;
                rbuf_v_d = 1'b0;
            end
        end else if (ms_valid_q && !rbuf_v_q) begin
            // reaching here implies ws_allowin=0: SRAM word is only live this cycle
            rbuf_d   = data_sram_rdata;
            rbuf_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            rbuf_v_q   <= 1'b0;
        end else begin
            ms_valid_q <= ms_valid_d;
            rbuf_v_q   <= rbuf_v_d;
        end
    end

    always_ff @(posedge clk) begin
        ms_bus_q <= ms_bus_d;
        rbuf_q   <= rbuf_d;
    end

    assign rd      = rbuf_v_q ? rbuf_q : data_sram_rdata;
    assign rd_half = p[1] ? rd[31:16] : rd[15:0];

    always_comb begin
        case (p)
            2'd0:    rd_byte = rd[7:0];
            2'd1:    rd_byte = rd[15:8];
            2'd2:    rd_byte = rd[23:16];
            default: rd_byte = rd[31:24];
        endcase
    end

    always_comb begin
        load_data = rd;
        if (ld_lb) begin
            load_data = {{24{rd_byte[7]}}, rd_byte};
        end else if (ld_lbu) begin
            load_data = {24'h0, rd_byte};
        end else if (ld_lh) begin
            load_data = {{16{rd_half[15]}}, rd_half};
        end else if (ld_lhu) begin
            load_data = {16'h0, rd_half};
        end else if (ld_lwl) begin
            case (p)
                2'd0:    load_data = {rd[7:0], 24'h0};
                2'd1:    load_data = {rd[15:0], 16'h0};
                2'd2:    load_data = {rd[23:0], 8'h0};
                default: load_data = rd;
            endcase
        end else if (ld_lwr) begin
            case (p)
                2'd0:    load_data = rd;
                2'd1:    load_data = {8'h0, rd[31:8]};
                2'd2:    load_data = {16'h0, rd[31:16]};
                default: load_data = {24'h0, rd[31:24]};
            endcase
        end else if (ld_lw) begin
            load_data = rd;
        end
    end

    always_comb begin
        rf_wen = 4'b1111;
        if (!ms_gr_we || ms_ex || !ms_valid_q) begin
            rf_wen = 4'b0000;
        end else if (ld_lwl) begin
            case (p)
                2'd0:    rf_wen = 4'b1000;
                2'd1:    rf_wen = 4'b1100;
                2'd2:    rf_wen = 4'b1110;
                default: rf_wen = 4'b1111;
            endcase
        end else if (ld_lwr) begin
            case (p)
                2'd0:    rf_wen = 4'b1111;
                2'd1:    rf_wen = 4'b0111;
                2'd2:    rf_wen = 4'b0011;
                default: rf_wen = 4'b0001;
            endcase
        end
    end

    // on an exception res carries BadVAddr, so it must win over load data
    assign final_result = (ms_res_from_mem && !ms_ex) ? load_data : ms_res;

    assign ms_to_ws_bus = {ms_root, ms_bd, ms_ex, ms_excode, rf_wen, ms_dest,
                           final_result, ms_pc};

    assign ms_fwd_bus = {ms_mfc0 && ms_valid_q,
                         ms_gr_we && ms_valid_q && !flush,
                         rf_wen, ms_dest, final_result};

endmodule
